// File: rtl/burst_line_master_if.sv
// Request/response and Avalon-MM burst signals of burst_line_master.
// "master" is the block's own view; "slave" is the view of whoever drives it.
interface burst_line_master_if #(parameter int ADDR = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [ADDR-1:0] req_addr;
  logic [127:0]    req_wdata;
  logic [15:0]     req_be;
  logic            resp_valid;
  logic            resp_write;
  logic [127:0]    resp_rdata;
  logic [ADDR-1:0] avm_addr;
  logic            avm_read;
  logic            avm_write;
  logic [2:0]      avm_burstcount;
  logic [31:0]     avm_writedata;
  logic [3:0]      avm_byteenable;
  logic [31:0]     avm_readdata;
  logic            avm_readdatavalid;
  logic            avm_waitrequest;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    output req_ready, resp_valid, resp_write, resp_rdata,
    output avm_addr, avm_read, avm_write, avm_burstcount, avm_writedata, avm_byteenable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  req_ready, resp_valid, resp_write, resp_rdata,
    input  avm_addr, avm_read, avm_write, avm_burstcount, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/burst_line_master.sv
// Line-fill / write-back master: one 16-byte line request becomes one 4-beat
// Avalon-MM burst; read beats are assembled, write beats serialised.
module burst_line_master #(
  parameter int ADDR = 32
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  burst_line_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_DATA, RESP} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [1:0]      cnt_nx;
  logic [3:0][31:0] line;
  logic [3:0][31:0] line_fill;
  logic [3:0][3:0] be;

  assign cnt_nx = cnt + 2'd1;

  // Line with the current read beat merged in, so the last beat can go
  // straight into resp_rdata on the same edge it is written.
  always_comb begin
    line_fill      = line;
    line_fill[cnt] = bus.avm_readdata;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      line               <= '0;
      be                 <= '0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_write     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.avm_addr       <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_burstcount <= '0;
      bus.avm_writedata  <= '0;
      bus.avm_byteenable <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready      <= 1'b0;
            cnt                <= '0;
            line               <= bus.req_wdata;
            be                 <= bus.req_be;
            bus.avm_addr       <= bus.req_addr & ~ADDR'(4'hF);
            bus.avm_burstcount <= 3'd4;
            if (bus.req_write) begin
              state              <= WR_DATA;
              bus.avm_write      <= 1'b1;
              bus.avm_writedata  <= bus.req_wdata[31:0];
              bus.avm_byteenable <= bus.req_be[3:0];
            end else begin
              state              <= RD_CMD;
              bus.avm_read       <= 1'b1;
              bus.avm_byteenable <= 4'hF;
            end
          end
        end
        RD_CMD: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_read       <= 1'b0;
            bus.avm_burstcount <= '0;
            state              <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.avm_readdatavalid) begin
            line <= line_fill;
            if (cnt == 2'd3) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_write <= 1'b0;
              bus.resp_rdata <= line_fill;
            end else begin
              cnt <= cnt_nx;
            end
          end
        end
        WR_DATA: begin
          if (!bus.avm_waitrequest) begin
            if (cnt == 2'd3) begin
              bus.avm_write      <= 1'b0;
              bus.avm_burstcount <= '0;
              state              <= RESP;
              bus.resp_valid     <= 1'b1;
              bus.resp_write     <= 1'b1;
              bus.resp_rdata     <= line;
            end else begin
              cnt                <= cnt_nx;
              bus.avm_writedata  <= line[cnt_nx];
              bus.avm_byteenable <= be[cnt_nx];
            end
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_line_master.sv
// Scoreboard bench for burst_line_master: a memory-level reference model predicts
// responses and bus beats; an Avalon slave model and a monitor check the DUT.
module tb_burst_line_master;
  localparam int ADDR = 32;

  typedef struct { logic w; logic [127:0] line; int lat; int t; } resp_t;
  typedef struct { logic [31:0] addr; int hold; int t; } cmd_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } beat_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  resp_t rq[$];
  cmd_t  cq[$];
  beat_t wq[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  int unsigned wait_pct = 0, gap_lo = 0, gap_hi = 0, stray_pct = 0;
  int          force_wait = 0;
  bit          stray_force = 1'b0;
  bit          real_beat = 1'b0;
  int          beats_given = 0;
  logic [127:0] last_rdata = '0;

  burst_line_master_if #(.ADDR(ADDR)) bus();

  burst_line_master #(.ADDR(ADDR)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},  128'(bus.req_ready), 128'(1));
    chk({tag, "_resp_valid"}, 128'(bus.resp_valid), 128'(0));
    chk({tag, "_resp_write"}, 128'(bus.resp_write), 128'(0));
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 128'(0));
    chk({tag, "_avm_rw"},     128'({bus.avm_read, bus.avm_write}), 128'(0));
    chk({tag, "_burstcount"}, 128'(bus.avm_burstcount), 128'(0));
    chk({tag, "_avm_addr"},   128'(bus.avm_addr), 128'(0));
  endtask

  // Issue one request; the expectation is pushed on the cycle it is accepted.
  task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] wd,
                       input logic [15:0] be, input int hold_exp);
    resp_t r;
    cmd_t  c;
    beat_t b;
    logic [31:0] base, word;
    bit ok = 1'b0;
    bit zw;
    int t;
    base = a & ~32'hF;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("req_accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    t  = cyc;
    zw = (wait_pct == 0 && gap_hi == 0 && force_wait == 0);
    r.w = w; r.t = t; r.lat = zw ? (w ? 5 : 6) : -1;
    if (w) begin
      r.line = wd;
      for (int k = 0; k < 4; k++) begin
        b.addr = base; b.data = wd[32*k +: 32]; b.be = be[4*k +: 4];
        wq.push_back(b);
        word = ref_rd(base + 32'(4*k));
        for (int j = 0; j < 4; j++)
          if (be[4*k+j]) word[8*j +: 8] = wd[32*k + 8*j +: 8];
        ref_mem[base + 32'(4*k)] = word;
      end
    end else begin
      for (int k = 0; k < 4; k++) r.line[32*k +: 32] = ref_rd(base + 32'(4*k));
      c.addr = base; c.hold = zw ? 1 : hold_exp; c.t = zw ? t + 1 : -1;
      cq.push_back(c);
    end
    rq.push_back(r);
    @(posedge clk_sys); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (rq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now({name, "_drain_timeout"});
    @(posedge clk_sys); #1;
  endtask

  // Avalon slave: random stalls, gapped read beats, stray readdatavalid pulses.
  initial begin : slave
    logic [31:0] pend[$];
    int gap = 0;
    int wb_idx = 0;
    logic [31:0] word, a;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(negedge clk_sys);
      if (rst_n) begin
        if (bus.avm_read && !bus.avm_waitrequest) begin
          for (int k = 0; k < 4; k++) pend.push_back(slv_rd(bus.avm_addr + 32'(4*k)));
          beats_given = 0;
          gap = int'($urandom_range(gap_hi, gap_lo));
        end
        if (bus.avm_write && !bus.avm_waitrequest) begin
          a = bus.avm_addr + 32'(4*wb_idx);
          word = slv_rd(a);
          for (int j = 0; j < 4; j++)
            if (bus.avm_byteenable[j]) word[8*j +: 8] = bus.avm_writedata[8*j +: 8];
          slv_mem[a] = word;
          wb_idx = (wb_idx + 1) % 4;
        end
      end
      @(posedge clk_sys); #1;
      if (!rst_n) begin
        pend.delete();
        wb_idx = 0;
      end
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = $urandom;
      real_beat             = 1'b0;
      if (pend.size() > 0) begin
        if (gap > 0) gap--;
        else begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = pend.pop_front();
          real_beat             = 1'b1;
          beats_given++;
          gap = int'($urandom_range(gap_hi, gap_lo));
        end
      end else if (stray_force || ($urandom_range(99) < stray_pct)) begin
        bus.avm_readdatavalid = 1'b1;
        stray_force = 1'b0;
      end
      if ((bus.avm_read || bus.avm_write) && force_wait > 0) begin
        bus.avm_waitrequest = 1'b1;
        force_wait--;
      end else begin
        bus.avm_waitrequest = ($urandom_range(99) < wait_pct);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or bus beat.
  initial begin : monitor
    resp_t r;
    cmd_t  c;
    beat_t b;
    bit busy = 1'b0;
    bit prev_rd_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    int hold = 0;
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        busy = 1'b0; prev_rd_wait = 1'b0; hold = 0;
        continue;
      end
      chk("req_ready", 128'(bus.req_ready), 128'(!busy));
      chk("burstcount", 128'(bus.avm_burstcount),
          128'((bus.avm_read || bus.avm_write) ? 3'd4 : 3'd0));
      if (prev_rd_wait) begin
        chk("rd_cmd_held", 128'(bus.avm_read), 128'(1));
        chk("rd_addr_stable", 128'(bus.avm_addr), 128'(prev_addr));
      end
      if (bus.avm_read) begin
        hold++;
        chk("rd_byteenable", 128'(bus.avm_byteenable), 128'(4'hF));
        if (!bus.avm_waitrequest) begin
          if (cq.size() == 0) fail_now("unexpected_rd_cmd");
          else begin
            c = cq.pop_front();
            chk("rd_addr", 128'(bus.avm_addr), 128'(c.addr));
            if (c.hold >= 0) chk("rd_cmd_hold", 128'(hold), 128'(c.hold));
            if (c.t >= 0) chk("rd_cmd_cycle", 128'(cyc), 128'(c.t));
          end
          hold = 0;
        end
      end
      prev_rd_wait = bus.avm_read && bus.avm_waitrequest;
      prev_addr    = bus.avm_addr;
      if (bus.avm_write && !bus.avm_waitrequest) begin
        if (wq.size() == 0) fail_now("unexpected_wr_beat");
        else begin
          b = wq.pop_front();
          chk("wr_addr", 128'(bus.avm_addr), 128'(b.addr));
          chk("wr_data", 128'(bus.avm_writedata), 128'(b.data));
          chk("wr_be", 128'(bus.avm_byteenable), 128'(b.be));
        end
      end
      if (bus.resp_valid) begin
        if (rq.size() == 0) fail_now("unexpected_resp");
        else begin
          r = rq.pop_front();
          chk("resp_write", 128'(bus.resp_write), 128'(r.w));
          chk("resp_rdata", bus.resp_rdata, r.line);
          if (r.lat >= 0) chk("resp_latency", 128'(cyc - r.t), 128'(r.lat));
          last_rdata = r.line;
        end
        busy = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) busy = 1'b1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset("por");
    rst_n = 1'b1;
    @(posedge clk_sys); #1;

    // Zero-wait line fill with known beat data.
    for (int k = 0; k < 4; k++) begin
      ref_mem[32'h1000 + 32'(4*k)] = 32'hA0 + 32'(k);
      slv_mem[32'h1000 + 32'(4*k)] = 32'hA0 + 32'(k);
    end
    issue(1'b0, 32'h1008, '0, '0, -1);
    drain("t1");

    // Command stalled three cycles, beats spaced by two idle cycles.
    force_wait = 3; gap_lo = 2; gap_hi = 2;
    issue(1'b0, 32'h1000, '0, '0, 4);
    drain("t2");
    gap_lo = 0; gap_hi = 0;

    // Write-back with partial enables under a toggling waitrequest.
    wait_pct = 50;
    issue(1'b1, 32'h2000, {32'h44, 32'h33, 32'h22, 32'h11}, 16'h0F0F, -1);
    drain("t3");
    wait_pct = 0;

    // Back-to-back read then write with req_valid kept asserted.
    issue(1'b0, 32'h2004, '0, '0, -1);
    issue(1'b1, 32'h2010, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, -1);
    drain("t4");

    // Stray readdatavalid while idle must not touch resp_rdata.
    stray_force = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("idle_stray_rdata", bus.resp_rdata, last_rdata);

    // Strays during write and command phases, then a read of the written line.
    stray_pct = 60; wait_pct = 60;
    issue(1'b1, 32'h2020, {$urandom, $urandom, $urandom, $urandom}, 16'hA5C3, -1);
    issue(1'b0, 32'h2020, '0, '0, -1);
    drain("t6");
    stray_pct = 0; wait_pct = 0;

    // Reset during the second read beat, followed by a late beat pulse.
    issue(1'b0, 32'h4000, '0, '0, -1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys);
      if (real_beat && bus.avm_readdatavalid && beats_given == 2) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("t5_beat2_timeout");
    rst_n = 1'b0;
    #1;
    chk_reset("midburst");
    rq.delete(); cq.delete(); wq.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    stray_force = 1'b1;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("post_reset_stray_rdata", bus.resp_rdata, 128'(0));
    issue(1'b0, 32'h4000, '0, '0, -1);
    drain("t5");

    // Randomised groups; knobs change only between drained groups.
    for (int g = 0; g < 6; g++) begin
      wait_pct  = (g % 2 == 0) ? 0 : 30;
      gap_lo    = 0;
      gap_hi    = (g % 3 == 2) ? 2 : 0;
      stray_pct = (g >= 3) ? 20 : 0;
      for (int n = 0; n < 8; n++) begin
        issue($urandom_range(1), 32'h3000 + 32'($urandom_range(7) * 16) + 32'($urandom_range(15)),
              {$urandom, $urandom, $urandom, $urandom}, 16'($urandom & $urandom), -1);
      end
      drain("rand");
    end
    stray_pct = 0;

    chk("leftover_resp", 128'(rq.size()), 128'(0));
    chk("leftover_cmd", 128'(cq.size()), 128'(0));
    chk("leftover_beats", 128'(wq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
